// File: rtl/reel_spin_sequencer.sv
// Reel spin sequencer: runs one slot-machine play. Three reels step on the fast
// spin strobe, then stop left-to-right, timed by the slow increment strobe.
module reel_spin_sequencer #(
   parameter int NUM_SYMBOLS = 8,
   parameter int SYM_W       = 3,
   parameter int SPIN_TICKS  = 4,
   parameter int STOP_GAP    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             spin_req,
   input  logic             credit_ok,
   input  logic             tick_spin,
   input  logic             tick_increment,
   output logic [SYM_W-1:0] reel0_pos,
   output logic [SYM_W-1:0] reel1_pos,
   output logic [SYM_W-1:0] reel2_pos,
   output logic [2:0]       reel_stopped,
   output logic             busy,
   output logic             credit_take,
   output logic             spin_done
);

   // The counter only has to reach the larger of the two intervals; it clears on every stop.
   localparam int MAX_T = (SPIN_TICKS > STOP_GAP) ? SPIN_TICKS : STOP_GAP;
   localparam int CNT_W = $clog2(MAX_T + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SPIN_ALL,
      S_STOP_R1,
      S_STOP_R2,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [SYM_W-1:0] r_pos0;
   logic [SYM_W-1:0] r_pos1;
   logic [SYM_W-1:0] r_pos2;
   logic [2:0]       r_stopped;
   logic             r_busy;
   logic             r_take;
   logic             r_done;

   logic             w_hit_spin;
   logic             w_hit_gap;
   logic [2:0]       w_stop_now;
   logic [2:0]       w_adv;

   // Next symbol index with wrap from the last symbol back to 0.
   function automatic logic [SYM_W-1:0] f_step(input logic [SYM_W-1:0] p);
      if (int'(p) == NUM_SYMBOLS - 1)
         return '0;
      else
         return p + SYM_W'(1);
   endfunction

   assign w_hit_spin = tick_increment && (int'(r_cnt) + 1 == SPIN_TICKS);
   assign w_hit_gap  = tick_increment && (int'(r_cnt) + 1 == STOP_GAP);

   // Which reel (if any) freezes on this edge; a freezing reel must not also step.
   always_comb begin
      w_stop_now = 3'b000;
      case (r_state)
         S_SPIN_ALL: w_stop_now[0] = w_hit_spin;
         S_STOP_R1:  w_stop_now[1] = w_hit_gap;
         S_STOP_R2:  w_stop_now[2] = w_hit_gap;
         default:    w_stop_now    = 3'b000;
      endcase
   end

   assign w_adv = {3{tick_spin}} & ~r_stopped & ~w_stop_now;

   // Play sequencing: accept, spin, staggered stops, single-cycle done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_stopped <= 3'b111;
         r_busy    <= 1'b0;
         r_take    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_take <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (spin_req && credit_ok) begin
                  r_state   <= S_SPIN_ALL;
                  r_busy    <= 1'b1;
                  r_take    <= 1'b1;
                  r_stopped <= 3'b000;
                  r_cnt     <= '0;
               end
            end
            S_SPIN_ALL: begin
               if (tick_increment) begin
                  if (w_hit_spin) begin
                     r_stopped[0] <= 1'b1;
                     r_cnt        <= '0;
                     r_state      <= S_STOP_R1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_STOP_R1: begin
               if (tick_increment) begin
                  if (w_hit_gap) begin
                     r_stopped[1] <= 1'b1;
                     r_cnt        <= '0;
                     r_state      <= S_STOP_R2;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_STOP_R2: begin
               if (tick_increment) begin
                  if (w_hit_gap) begin
                     r_stopped[2] <= 1'b1;
                     r_cnt        <= '0;
                     r_done       <= 1'b1;
                     r_state      <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Reel positions: step unfrozen reels on tick_spin; values persist between plays.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pos0 <= '0;
         r_pos1 <= '0;
         r_pos2 <= '0;
      end else begin
         if (w_adv[0]) r_pos0 <= f_step(r_pos0);
         if (w_adv[1]) r_pos1 <= f_step(r_pos1);
         if (w_adv[2]) r_pos2 <= f_step(r_pos2);
      end
   end

   assign reel0_pos    = r_pos0;
   assign reel1_pos    = r_pos1;
   assign reel2_pos    = r_pos2;
   assign reel_stopped = r_stopped;
   assign busy         = r_busy;
   assign credit_take  = r_take;
   assign spin_done    = r_done;

endmodule

// File: tb/tb_reel_spin_sequencer.sv
// Bench for reel_spin_sequencer: an 8-symbol and a 5-symbol instance share stimulus
// and are tracked by a play-level reference model.
module tb_reel_spin_sequencer;

   localparam int ST = 2;
   localparam int SG = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, spin_req, credit_ok, tick_spin, tick_increment;
   logic [2:0] a_r0, a_r1, a_r2, a_stop, b_r0, b_r1, b_r2, b_stop;
   logic a_busy, a_take, a_done, b_busy, b_take, b_done;

   reel_spin_sequencer #(.NUM_SYMBOLS(8), .SYM_W(3), .SPIN_TICKS(ST), .STOP_GAP(SG)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .spin_req(spin_req), .credit_ok(credit_ok),
      .tick_spin(tick_spin), .tick_increment(tick_increment),
      .reel0_pos(a_r0), .reel1_pos(a_r1), .reel2_pos(a_r2), .reel_stopped(a_stop),
      .busy(a_busy), .credit_take(a_take), .spin_done(a_done));

   reel_spin_sequencer #(.NUM_SYMBOLS(5), .SYM_W(3), .SPIN_TICKS(ST), .STOP_GAP(SG)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .spin_req(spin_req), .credit_ok(credit_ok),
      .tick_spin(tick_spin), .tick_increment(tick_increment),
      .reel0_pos(b_r0), .reel1_pos(b_r1), .reel2_pos(b_r2), .reel_stopped(b_stop),
      .busy(b_busy), .credit_take(b_take), .spin_done(b_done));

   int vecs = 0;
   int errs = 0;

   // Reference model: play tracked as "increment pulses since accept" against stop thresholds.
   int         m_pos8 [3];
   int         m_pos5 [3];
   logic [2:0] m_stop = 3'b111;
   bit         m_busy = 0, m_take = 0, m_done = 0;
   int         m_incs = 0;

   function automatic int thr(input int i);
      return ST + i * SG;
   endfunction

   task automatic model_step(input logic r, input logic sr, input logic co, input logic ts, input logic ti);
      bit take_n, done_n;
      take_n = 0;
      done_n = 0;
      if (!r) begin
         for (int i = 0; i < 3; i++) begin m_pos8[i] = 0; m_pos5[i] = 0; end
         m_stop = 3'b111; m_busy = 0; m_incs = 0;
      end else if (!m_busy) begin
         if (sr && co) begin
            m_busy = 1; take_n = 1; m_stop = 3'b000; m_incs = 0;
         end
      end else if (m_done) begin
         m_busy = 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (ts && !m_stop[i] && !(ti && (m_incs + 1 == thr(i)))) begin
               m_pos8[i] = (m_pos8[i] + 1) % 8;
               m_pos5[i] = (m_pos5[i] + 1) % 5;
            end
         end
         if (ti) begin
            m_incs++;
            for (int i = 0; i < 3; i++) if (m_incs >= thr(i)) m_stop[i] = 1'b1;
         end
         if (m_stop[2]) done_n = 1;
      end
      m_take = take_n;
      m_done = done_n;
   endtask

   task automatic step(input logic r, input logic sr, input logic co, input logic ts, input logic ti);
      rst_n = r; spin_req = sr; credit_ok = co; tick_spin = ts; tick_increment = ti;
      @(posedge clk);
      model_step(r, sr, co, ts, ti);
      #1;
   endtask

   function automatic logic [14:0] obs_a();
      return {a_r0, a_r1, a_r2, a_stop, a_busy, a_take, a_done};
   endfunction
   function automatic logic [14:0] obs_b();
      return {b_r0, b_r1, b_r2, b_stop, b_busy, b_take, b_done};
   endfunction
   function automatic logic [14:0] exp_a();
      return {3'(m_pos8[0]), 3'(m_pos8[1]), 3'(m_pos8[2]), m_stop, m_busy, m_take, m_done};
   endfunction
   function automatic logic [14:0] exp_b();
      return {3'(m_pos5[0]), 3'(m_pos5[1]), 3'(m_pos5[2]), m_stop, m_busy, m_take, m_done};
   endfunction

   function automatic logic rb(input int den);
      return ($urandom_range(0, den - 1) == 0);
   endfunction

   task automatic test_reset;
      for (int c = 0; c < 3; c++) begin
         step(1'b0, rb(2), rb(2), rb(2), rb(2));
         vecs++;
         if (obs_a() !== 15'b000_000_000_111_000) begin
            errs++; $display("FAIL reset8 cyc%0d got=%b exp=%b", c, obs_a(), 15'b000_000_000_111_000);
         end
         vecs++;
         if (obs_b() !== exp_b()) begin
            errs++; $display("FAIL reset5 cyc%0d got=%b exp=%b", c, obs_b(), exp_b());
         end
      end
   endtask

   task automatic test_full_play;
      logic [3:0] seq [16];
      int takes, dones;
      seq = '{4'b1100, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001,
              4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0000};
      takes = 0; dones = 0;
      for (int c = 0; c < 16; c++) begin
         step(1'b1, seq[c][3], seq[c][2], seq[c][1], seq[c][0]);
         takes += int'(a_take); dones += int'(a_done);
         vecs++;
         if (obs_a() !== exp_a()) begin
            errs++; $display("FAIL play_model cyc%0d got=%b exp=%b", c, obs_a(), exp_a());
         end
         if (c == 7) begin
            vecs++;
            if ({a_stop, a_r0, a_r1, a_r2} !== {3'b001, 3'd5, 3'd5, 3'd5}) begin
               errs++; $display("FAIL play_stop0 got=%b/%0d/%0d/%0d exp=001/5/5/5", a_stop, a_r0, a_r1, a_r2);
            end
         end
         if (c == 11) begin
            vecs++;
            if ({a_stop, a_r0, a_r1, a_r2} !== {3'b011, 3'd5, 3'd0, 3'd0}) begin
               errs++; $display("FAIL play_stop1 got=%b/%0d/%0d/%0d exp=011/5/0/0", a_stop, a_r0, a_r1, a_r2);
            end
         end
         if (c == 14) begin
            vecs++;
            if ({a_stop, a_r0, a_r1, a_r2, a_done} !== {3'b111, 3'd5, 3'd0, 3'd2, 1'b1}) begin
               errs++; $display("FAIL play_final got=%b/%0d/%0d/%0d done=%b exp=111/5/0/2 done=1",
                                a_stop, a_r0, a_r1, a_r2, a_done);
            end
         end
      end
      vecs++;
      if (takes != 1 || dones != 1) begin
         errs++; $display("FAIL play_pulses takes=%0d dones=%0d exp=1/1", takes, dones);
      end
      vecs++;
      if (a_busy !== 1'b0) begin
         errs++; $display("FAIL play_busy_drop got=%b exp=0", a_busy);
      end
   endtask

   task automatic test_no_credit;
      logic [8:0] p0;
      p0 = {a_r0, a_r1, a_r2};
      for (int c = 0; c < 21; c++) begin
         step(1'b1, (c == 0), 1'b0, rb(2), rb(2));
         vecs++;
         if ({a_busy, a_take, a_r0, a_r1, a_r2} !== {2'b00, p0}) begin
            errs++; $display("FAIL nocredit cyc%0d got=%b/%b/%h exp=0/0/%h", c, a_busy, a_take,
                             {a_r0, a_r1, a_r2}, p0);
         end
         vecs++;
         if (obs_b() !== exp_b()) begin
            errs++; $display("FAIL nocredit5 cyc%0d got=%b exp=%b", c, obs_b(), exp_b());
         end
      end
   endtask

   task automatic test_collision;
      logic [2:0] p0, p1, p2;
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      p0 = a_r0; p1 = a_r1; p2 = a_r2;
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      vecs++;
      if ({a_stop, a_r0, a_r1, a_r2} !== {3'b001, p0, 3'(p1 + 3'd1), 3'(p2 + 3'd1)}) begin
         errs++; $display("FAIL collision got=%b/%0d/%0d/%0d exp=001/%0d/%0d/%0d", a_stop, a_r0, a_r1, a_r2,
                          p0, 3'(p1 + 3'd1), 3'(p2 + 3'd1));
      end
      for (int c = 0; c < 4; c++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1, (c < 2));
         vecs++;
         if (obs_a() !== exp_a() || obs_b() !== exp_b()) begin
            errs++; $display("FAIL collision_tail cyc%0d got=%b/%b exp=%b/%b", c, obs_a(), obs_b(), exp_a(), exp_b());
         end
      end
   endtask

   task automatic test_back_to_back;
      int takes, dones, cyc;
      bit seen;
      takes = 0; dones = 0; cyc = 0; seen = 0;
      while (!seen && cyc < 500) begin
         step(1'b1, 1'b1, 1'b1, rb(2), rb(3));
         takes += int'(a_take); dones += int'(a_done);
         if (a_done) seen = 1;
         cyc++;
         vecs++;
         if (obs_a() !== exp_a()) begin
            errs++; $display("FAIL abuse_model cyc%0d got=%b exp=%b", cyc, obs_a(), exp_a());
         end
      end
      vecs++;
      if (!seen) begin
         errs++; $display("FAIL abuse_timeout got=no spin_done exp=spin_done within 500 cycles");
      end
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      takes += int'(a_take);
      vecs++;
      if (takes != 1 || dones != 1 || a_busy !== 1'b0) begin
         errs++; $display("FAIL abuse_pulses takes=%0d dones=%0d busy=%b exp=1/1/0", takes, dones, a_busy);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Second play, aborted by reset while the middle reel is still spinning.
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc = 0;
      while (a_stop !== 3'b001 && cyc < 20) begin
         step(1'b1, 1'b0, 1'b0, rb(2), 1'b1);
         cyc++;
      end
      vecs++;
      if (a_stop !== 3'b001) begin
         errs++; $display("FAIL abort_reach got=%b exp=001", a_stop);
      end
      step(1'b0, rb(2), rb(2), rb(2), rb(2));
      vecs++;
      if (obs_a() !== 15'b000_000_000_111_000) begin
         errs++; $display("FAIL abort_reset got=%b exp=%b", obs_a(), 15'b000_000_000_111_000);
      end
      for (int c = 0; c < 3; c++) begin
         step(1'b1, 1'b0, 1'b0, rb(2), rb(2));
         vecs++;
         if (a_done !== 1'b0 || a_busy !== 1'b0 || obs_a() !== exp_a()) begin
            errs++; $display("FAIL abort_idle cyc%0d got=%b exp=%b", c, obs_a(), exp_a());
         end
      end
   endtask

   task automatic test_wrap;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 12; c++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs++;
      if ({b_r0, b_r1, b_r2} !== {3'd2, 3'd2, 3'd2}) begin
         errs++; $display("FAIL wrap5 got=%0d/%0d/%0d exp=2/2/2", b_r0, b_r1, b_r2);
      end
      vecs++;
      if ({a_r0, a_r1, a_r2} !== {3'd4, 3'd4, 3'd4}) begin
         errs++; $display("FAIL wrap8 got=%0d/%0d/%0d exp=4/4/4", a_r0, a_r1, a_r2);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random;
      for (int c = 0; c < 600; c++) begin
         step(!rb(60), rb(5), !rb(4), rb(2), rb(4));
         vecs++;
         if (obs_a() !== exp_a()) begin
            errs++; $display("FAIL rand8 cyc%0d got=%b exp=%b", c, obs_a(), exp_a());
         end
         vecs++;
         if (obs_b() !== exp_b()) begin
            errs++; $display("FAIL rand5 cyc%0d got=%b exp=%b", c, obs_b(), exp_b());
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin m_pos8[i] = 0; m_pos5[i] = 0; end
      rst_n = 1'b0; spin_req = 1'b0; credit_ok = 1'b0; tick_spin = 1'b0; tick_increment = 1'b0;
      test_reset;
      test_full_play;
      test_no_credit;
      test_collision;
      test_back_to_back;
      test_wrap;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
